// File: rtl/cram_cfg_sequencer.sv
// rtl/cram_cfg_sequencer.sv - upstream write sequencer for the 16x4 misc/clock-mux tile CRAM
//
// Purpose: accepts one COLS-bit config word per row over a valid/ready stream
// and drives the CRAM row clear, bit lines, pass gates, word-line strobes and
// row supply. It holds the tile's prog flag high for the whole session, so every
// mux stays tri-stated until the configuration is complete.
//
// Ports:
//   i_clk           tile configuration clock, rising edge
//   i_reset_b       asynchronous active-low reset
//   i_start         1-cycle pulse in IDLE: begin a session (CLEAR, then rows 0..ROWS-1)
//   i_abort         level, honoured outside IDLE: terminate the session, set err
//   i_pwr_dn        level, honoured only in IDLE: remove the row supply
//   i_in_valid      config word available
//   i_in_data       config word for the current row (bit j -> bl[j])
//   o_in_ready      high only in LOAD
//   o_wl            one-hot write strobe, zero outside WRITE
//   o_bl            bit-line data
//   o_bl_oe         bit-line driver enable
//   o_pgate         one-hot row pass-gate enable
//   o_cram_reset_b  active-low row clear, all rows together
//   o_vdd_cntl      active-low row supply gate (0 = powered)
//   o_prog          tile program-mode flag
//   o_busy          high in every state except IDLE
//   o_done          1-cycle pulse on successful completion
//   o_err           sticky abort flag, cleared by the next accepted start
module cram_cfg_sequencer #(
  parameter int ROWS      = 16,
  parameter int COLS      = 4,
  parameter int CLR_CYC   = 4,
  parameter int SETUP_CYC = 2,
  parameter int WL_CYC    = 3
) (
  input  logic            i_clk,
  input  logic            i_reset_b,
  input  logic            i_start,
  input  logic            i_abort,
  input  logic            i_pwr_dn,
  input  logic            i_in_valid,
  input  logic [COLS-1:0] i_in_data,
  output logic            o_in_ready,
  output logic [ROWS-1:0] o_wl,
  output logic [COLS-1:0] o_bl,
  output logic            o_bl_oe,
  output logic [ROWS-1:0] o_pgate,
  output logic [ROWS-1:0] o_cram_reset_b,
  output logic [ROWS-1:0] o_vdd_cntl,
  output logic            o_prog,
  output logic            o_busy,
  output logic            o_done,
  output logic            o_err
);

  localparam int ROW_W   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int MAX_A   = (CLR_CYC > SETUP_CYC) ? CLR_CYC : SETUP_CYC;
  localparam int MAX_CYC = (MAX_A > WL_CYC) ? MAX_A : WL_CYC;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0] CLR_LAST   = CNT_W'(CLR_CYC - 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] WL_LAST    = CNT_W'(WL_CYC - 1);
  localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(ROWS - 1);
  localparam logic [ROWS-1:0]  ROW_ONE    = ROWS'(1);
  localparam logic [ROWS-1:0]  ROW_ALL    = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_LOAD, S_SETUP, S_WRITE, S_HOLD, S_DONE
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [ROW_W-1:0]  r_row, w_row_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [COLS-1:0]   r_word, w_word_nxt;
  logic              r_err, w_err_nxt;

  logic              r_in_ready, w_in_ready_nxt;
  logic [ROWS-1:0]   r_wl, w_wl_nxt;
  logic              r_bl_oe, w_bl_oe_nxt;
  logic [ROWS-1:0]   r_pgate, w_pgate_nxt;
  logic [ROWS-1:0]   r_cram_reset_b, w_cram_reset_b_nxt;
  logic [ROWS-1:0]   r_vdd_cntl, w_vdd_cntl_nxt;
  logic              r_prog, w_prog_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;
  logic [ROWS-1:0]   w_row_sel;
  logic              w_drive;

  always_ff @(posedge i_clk or negedge i_reset_b) begin
    if (!i_reset_b) begin
      r_state        <= S_IDLE;
      r_row          <= '0;
      r_cnt          <= '0;
      r_word         <= '0;
      r_err          <= 1'b0;
      r_in_ready     <= 1'b0;
      r_wl           <= '0;
      r_bl_oe        <= 1'b0;
      r_pgate        <= '0;
      r_cram_reset_b <= ROW_ALL;
      r_vdd_cntl     <= '0;
      r_prog         <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_row          <= w_row_nxt;
      r_cnt          <= w_cnt_nxt;
      r_word         <= w_word_nxt;
      r_err          <= w_err_nxt;
      r_in_ready     <= w_in_ready_nxt;
      r_wl           <= w_wl_nxt;
      r_bl_oe        <= w_bl_oe_nxt;
      r_pgate        <= w_pgate_nxt;
      r_cram_reset_b <= w_cram_reset_b_nxt;
      r_vdd_cntl     <= w_vdd_cntl_nxt;
      r_prog         <= w_prog_nxt;
      r_busy         <= w_busy_nxt;
      r_done         <= w_done_nxt;
    end
  end

  // Every output register is loaded from a decode of the *next* state, so the
  // outputs line up with the state they belong to while staying registered.
  always_comb begin
    w_state_nxt = r_state;
    w_row_nxt   = r_row;
    w_cnt_nxt   = r_cnt;
    w_word_nxt  = r_word;
    w_err_nxt   = r_err;

    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_nxt = S_CLEAR;
          w_cnt_nxt   = '0;
          w_err_nxt   = 1'b0;
        end
      end
      S_CLEAR: begin
        if (r_cnt == CLR_LAST) begin
          w_state_nxt = S_LOAD;
          w_row_nxt   = '0;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_LOAD: begin
        // in_ready is registered high for the whole of LOAD, so valid alone
        // completes the handshake here.
        if (i_in_valid) begin
          w_word_nxt  = i_in_data;
          w_state_nxt = S_SETUP;
          w_cnt_nxt   = '0;
        end
      end
      S_SETUP: begin
        if (r_cnt == SETUP_LAST) begin
          w_state_nxt = S_WRITE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_WRITE: begin
        if (r_cnt == WL_LAST) begin
          w_state_nxt = S_HOLD;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (r_row == ROW_LAST) begin
          w_state_nxt = S_DONE;
        end else begin
          w_row_nxt   = r_row + ROW_W'(1);
          w_state_nxt = S_LOAD;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_row_nxt   = '0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_row_nxt   = '0;
        w_cnt_nxt   = '0;
      end
    endcase

    // Abort overrides everything, including the last HOLD -> DONE step.
    if (i_abort && (r_state != S_IDLE)) begin
      w_state_nxt = S_IDLE;
      w_row_nxt   = '0;
      w_cnt_nxt   = '0;
      w_err_nxt   = 1'b1;
    end

    w_row_sel = ROW_ONE << w_row_nxt;
    w_drive   = (w_state_nxt == S_SETUP) || (w_state_nxt == S_WRITE) ||
                (w_state_nxt == S_HOLD);

    w_in_ready_nxt     = (w_state_nxt == S_LOAD);
    w_wl_nxt           = (w_state_nxt == S_WRITE) ? w_row_sel : '0;
    w_pgate_nxt        = w_drive ? w_row_sel : '0;
    w_bl_oe_nxt        = w_drive;
    w_cram_reset_b_nxt = (w_state_nxt == S_CLEAR) ? '0 : ROW_ALL;
    w_prog_nxt         = (w_state_nxt != S_IDLE) && (w_state_nxt != S_DONE);
    w_busy_nxt         = (w_state_nxt != S_IDLE);
    w_done_nxt         = (w_state_nxt == S_DONE);
    // Supply is only gated off while idling; an accepted start powers rows at once.
    w_vdd_cntl_nxt     = ((r_state == S_IDLE) && i_pwr_dn && !i_start) ? ROW_ALL : '0;
  end

  assign o_in_ready     = r_in_ready;
  assign o_wl           = r_wl;
  assign o_bl           = r_word;
  assign o_bl_oe        = r_bl_oe;
  assign o_pgate        = r_pgate;
  assign o_cram_reset_b = r_cram_reset_b;
  assign o_vdd_cntl     = r_vdd_cntl;
  assign o_prog         = r_prog;
  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_err          = r_err;

endmodule
